ysyx_25040118_seq_ctrl: RTL
===========================

# ysyx_25040118_seq_ctrl

Multi-cycle sequencer for the NPC core.
- Drives the instruction-fetch handshake and latches the fetched instruction for the decoder.
- Uses the decoder's class flags (load/store/branch/jal/jalr/system/ebreak) to choose the execution path.
- Sequences the load/store unit, then issues the PC and register-file write strobes.
- Halts the core on `ebreak`, and optionally on a bus timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: consecutive wait cycles in FETCH or MEM before a timeout halt (used only with the macro in Configuration); legal range 2..65535.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ifu_req`  out  1  fetch request; held high in FETCH.
- `ifu_rvalid`  in  1  fetch response valid; sampled only in FETCH.
- `inst_we`  out  1  one-cycle pulse latching the instruction register.
- `is_load`, `is_store`, `is_branch`, `is_jal`, `is_jalr`, `is_system`, `ebreak`  in  1 each  decoder flags; sampled only in DECODE.
- `lsu_req`  out  1  memory request; held high in MEM.
- `lsu_wen`  out  1  1 = store, 0 = load; valid while `lsu_req` is high.
- `lsu_rvalid`  in  1  memory completion; sampled only in MEM.
- `pc_we`  out  1  PC update strobe.
- `rf_we`  out  1  register-file write strobe.
- `stop`  out  1  core halted.
- `timeout`  out  1  sticky bus-timeout flag.
- `state`  out  3  current state, for debug.
- `inst_cnt`  out  32  retired-instruction counter.

## Operation
State encoding:
- FETCH = 0, DECODE = 1, MEM = 2, WB = 3, HALT = 4.
- Codes 5–7 are unreachable. If one is reached, the next state is FETCH.

FETCH:
- `ifu_req` = 1.
- When `ifu_rvalid` = 1: `inst_we` = 1 in that same cycle, and the next state is DECODE.
- Otherwise the block stays in FETCH.

DECODE (exactly one cycle):
- If `ebreak` = 1, go to HALT. This has priority over all other flags.
- Else if `is_load` or `is_store`, go to MEM. `lsu_wen` is registered as `is_store`.
- Else go to WB.

MEM:
- `lsu_req` = 1, and `lsu_wen` is held.
- When `lsu_rvalid` = 1, go to WB. Otherwise stay in MEM.

WB (exactly one cycle):
- `pc_we` = 1.
- `rf_we` = 1 unless the latched class is store, branch or system.
- `inst_cnt` += 1; it wraps from 0xFFFFFFFF to 0.
- Next state is FETCH.

HALT:
- `stop` = 1.
- All request and strobe outputs are 0.
- The block stays in HALT until `rst`.

General rules:
- The decoder flags are latched in DECODE into internal class registers; WB uses these latched values.
- Responses arriving outside their sampling state are ignored.

## Timing
- Reset values: the state is FETCH.
  - `ifu_req` reads 1 in the first cycle after reset, because it is combinational from the state.
  - All other outputs are 0, and `inst_cnt` = 0.
- Outputs `ifu_req`, `lsu_req`, `inst_we`, `pc_we`, `rf_we` and `stop` are decoded combinationally from the state (plus `ifu_rvalid` for `inst_we`).
- Zero-wait fetch means `ifu_rvalid` is high in the first FETCH cycle. With zero-wait fetch:
  - An ALU, branch or jump instruction takes 3 cycles (FETCH, DECODE, WB).
  - A load or store with zero-wait memory takes 4 cycles.
- Each wait cycle adds 1 cycle.
- `pc_we` and `rf_we` assert on the same cycle, at most once per instruction.
- Reset mid-operation:
  - The next cycle is FETCH.
  - Any outstanding `ifu_req`/`lsu_req` is dropped without completion; the bus must tolerate an abandoned request.
  - `timeout` and `inst_cnt` are cleared.
- `ebreak` in DECODE: `pc_we` and `rf_we` never pulse, and `inst_cnt` is not incremented.

## Configuration
- Macro `YSYX_25040118_BUS_TIMEOUT_EN`.
- Defined:
  - A 16-bit wait counter clears on entry to FETCH or MEM and increments on each wait cycle.
  - When it reaches `TIMEOUT_CYCLES`, the next state is HALT and `timeout` is set to 1.
  - If `rvalid` arrives in that expiry cycle, the response wins and there is no timeout.
- Undefined:
  - The counter is not built.
  - `timeout` is tied to 0.
  - Waits are unbounded.

## Test plan
- `rst` for 2 cycles, then `ifu_rvalid` = 1 constantly with ALU flags → `inst_we` on cycles 0, 3, 6; `pc_we` and `rf_we` on cycles 2, 5, 8; `inst_cnt` = 3 after 9 cycles.
- Load with `ifu_rvalid` delayed 2 cycles and `lsu_rvalid` delayed 3 cycles → `lsu_req` high for 4 cycles with `lsu_wen` = 0; `rf_we` = 1 in WB; 9 cycles in total.
- Store, then branch → `lsu_wen` = 1; `rf_we` = 0 for both instructions; `pc_we` = 1 for both.
- `ebreak` in DECODE → `stop` = 1 from the next cycle; it holds for 100 cycles while `ifu_req` = 0 and `inst_cnt` is unchanged; `rst` returns the block to FETCH.
- With the macro, `TIMEOUT_CYCLES` = 4, and `lsu_rvalid` never asserted → HALT and `timeout` = 1 after 4 MEM cycles. With `lsu_rvalid` asserted in the 4th MEM cycle → WB instead.
- `inst_cnt` preloaded (forced) to 0xFFFFFFFF, then one instruction retires → `inst_cnt` = 0.

Source files
------------

// File: rtl/ysyx_25040118_seq_ctrl_if.sv
// ysyx_25040118_seq_ctrl_if: fetch and load/store handshake bundle.
// The sequencer takes the master side; the memory side takes the slave side.
interface ysyx_25040118_seq_ctrl_if;
    logic ifu_req;
    logic ifu_rvalid;
    logic lsu_req;
    logic lsu_wen;
    logic lsu_rvalid;

    modport master (
        output ifu_req,
        output lsu_req,
        output lsu_wen,
        input  ifu_rvalid,
        input  lsu_rvalid
    );

    modport slave (
        input  ifu_req,
        input  lsu_req,
        input  lsu_wen,
        output ifu_rvalid,
        output lsu_rvalid
    );
endinterface

// File: rtl/ysyx_25040118_seq_ctrl.sv
// ysyx_25040118_seq_ctrl: multi-cycle FETCH/DECODE/MEM/WB/HALT sequencer for the NPC core.
// Define YSYX_25040118_BUS_TIMEOUT_EN to halt when a fetch or memory wait runs too long.
module ysyx_25040118_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    ysyx_25040118_seq_ctrl_if.master bus,
    output logic        inst_we,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        is_system,
    input  logic        ebreak,
    output logic        pc_we,
    output logic        rf_we,
    output logic        stop,
    output logic        timeout,
    output logic [2:0]  state,
    output logic [31:0] inst_cnt
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_MEM    = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic        wen_q;
    logic        rf_q;
    logic [31:0] cnt_q;
    logic        expire;

    // Jumps retire exactly like ALU ops, so their flags need no path of their own.
    logic unused_flags;
    assign unused_flags = is_jal ^ is_jalr;

`ifdef YSYX_25040118_BUS_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_q;
    logic        to_q;
    logic        waiting;

    assign waiting = (state_q == S_FETCH && !bus.ifu_rvalid) ||
                     (state_q == S_MEM && !bus.lsu_rvalid);

    // A response in the last allowed cycle still wins over the watchdog.
    assign expire = waiting && (wait_q == TO_LAST);

    // Wait counter restarts whenever the state changes (every entry into FETCH or MEM).
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= 16'd0;
        end else if (state_d != state_q) begin
            wait_q <= 16'd0;
        end else if (waiting) begin
            wait_q <= wait_q + 16'd1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_q <= 1'b0;
        end else if (expire) begin
            to_q <= 1'b1;
        end
    end

    assign timeout = to_q;
`else
    // No watchdog: waits are unbounded and the flag stays low.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; ebreak outranks every other class flag.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.ifu_rvalid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ebreak) begin
                    state_d = S_HALT;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.lsu_rvalid) begin
                    state_d = S_WB;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        if (expire) begin
            state_d = S_HALT;
        end
    end

    // Class latch taken in DECODE and consumed by MEM and WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q <= 1'b0;
            rf_q  <= 1'b0;
        end else if (state_q == S_DECODE) begin
            wen_q <= is_store;
            rf_q  <= !(is_store || is_branch || is_system);
        end
    end

    // Retired-instruction counter, wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else if (state_q == S_WB) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // Requests and strobes decoded straight from the current state.
    always_comb begin
        bus.ifu_req = (state_q == S_FETCH);
        bus.lsu_req = (state_q == S_MEM);
        bus.lsu_wen = (state_q == S_MEM) && wen_q;
        inst_we     = (state_q == S_FETCH) && bus.ifu_rvalid;
        pc_we       = (state_q == S_WB);
        rf_we       = (state_q == S_WB) && rf_q;
        stop        = (state_q == S_HALT);
    end

    assign state    = state_q;
    assign inst_cnt = cnt_q;

endmodule
